// File: rtl/time_pkg.sv
// Shared encodings, field limits and wrap-around arithmetic for the time-set controller.
package time_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EDIT_HRS = 3'd1,
        ST_EDIT_MIN = 3'd2,
        ST_EDIT_SEC = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    localparam logic [4:0] HRS_MAX = 5'd23;
    localparam logic [5:0] MS_MAX  = 6'd59;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HRS  = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    function automatic logic [4:0] hrs_step(input logic [4:0] v, input logic up);
        if (up)
            return (v >= HRS_MAX) ? 5'd0 : v + 5'd1;
        else
            return (v == 5'd0 || v > HRS_MAX) ? HRS_MAX : v - 5'd1;
    endfunction

    function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
        if (up)
            return (v >= MS_MAX) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0 || v > MS_MAX) ? MS_MAX : v - 6'd1;
    endfunction

    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HRS) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            ST_EDIT_HRS: return FIELD_HRS;
            ST_EDIT_MIN: return FIELD_MIN;
            ST_EDIT_SEC: return FIELD_SEC;
            default:     return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat timing for one debounced button.
module btn_repeat #(
    parameter int unsigned HOLD_CYC = 500,
    parameter int unsigned REP_CYC  = 100
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn,
    input  logic restart,
    output logic press,
    output logic step
);

    localparam int unsigned CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW = $clog2(CNT_MAX + 1);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          rpt;

    assign press = btn & ~btn_q;
    assign rpt   = btn & btn_q & (cnt == '0);
    assign step  = press | rpt;

    // Down-counter: loaded with the hold delay on the edge, then the repeat period.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            btn_q <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            if (!btn)
                cnt <= '0;
            else if (press || restart)
                cnt <= CW'(HOLD_CYC - 1);
            else if (cnt == '0)
                cnt <= CW'(REP_CYC - 1);
            else
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-set controller: captures the running time, edits hrs/min/sec, commits.
//  state       | meaning
//  ST_IDLE     | not editing, outputs quiet
//  ST_EDIT_HRS | editing hours
//  ST_EDIT_MIN | editing minutes
//  ST_EDIT_SEC | editing seconds
//  ST_COMMIT   | one-cycle load_o strobe, then back to idle
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 500,
    parameter int unsigned REP_CYC     = 100,
    parameter int unsigned BLINK_CYC   = 250,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hrs,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hrs,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load_o,
    output logic       edit_o,
    output logic [1:0] field_o,
    output logic       blink_o
);

    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, state_nxt;
    logic          sel_q, sel_edge;
    logic          inc_press, inc_step, dec_press, dec_step;
    logic          both_held, any_edge, in_edit, tmo_hit;
    logic          do_up, do_dn, stepped;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] tmo_cnt;

    assign both_held = btn_inc & btn_dec;

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_inc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn     (btn_inc),
        .restart (both_held),
        .press   (inc_press),
        .step    (inc_step)
    );

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dec (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn     (btn_dec),
        .restart (both_held),
        .press   (dec_press),
        .step    (dec_step)
    );

    assign sel_edge = btn_sel & ~sel_q;
    assign any_edge = sel_edge | inc_press | dec_press;
    assign in_edit  = is_edit(state);
    assign tmo_hit  = (tmo_cnt == '0) & ~any_edge;

    // A select edge wins over inc/dec; the opposite button being held blocks a step.
    assign do_up   = in_edit & ~sel_edge & inc_step & ~btn_dec;
    assign do_dn   = in_edit & ~sel_edge & dec_step & ~btn_inc;
    assign stepped = do_up | do_dn;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sel_edge)
                    state_nxt = ST_EDIT_HRS;
            end
            ST_EDIT_HRS: begin
                if (sel_edge)
                    state_nxt = ST_EDIT_MIN;
                else if (tmo_hit)
                    state_nxt = ST_IDLE;
            end
            ST_EDIT_MIN: begin
                if (sel_edge)
                    state_nxt = ST_EDIT_SEC;
                else if (tmo_hit)
                    state_nxt = ST_IDLE;
            end
            ST_EDIT_SEC: begin
                if (sel_edge)
                    state_nxt = ST_COMMIT;
                else if (tmo_hit)
                    state_nxt = ST_IDLE;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sel_q   <= 1'b0;
            edit_o  <= 1'b0;
            field_o <= FIELD_NONE;
            load_o  <= 1'b0;
        end else begin
            sel_q   <= btn_sel;
            edit_o  <= is_edit(state_nxt);
            field_o <= field_of(state_nxt);
            load_o  <= (state_nxt == ST_COMMIT);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            set_hrs <= '0;
            set_min <= '0;
            set_sec <= '0;
        end else if (state == ST_IDLE && sel_edge) begin
            set_hrs <= (cur_hrs > HRS_MAX) ? HRS_MAX : cur_hrs;
            set_min <= (cur_min > MS_MAX) ? MS_MAX : cur_min;
            set_sec <= (cur_sec > MS_MAX) ? MS_MAX : cur_sec;
        end else if (stepped) begin
            case (state)
                ST_EDIT_HRS: set_hrs <= hrs_step(set_hrs, do_up);
                ST_EDIT_MIN: set_min <= ms_step(set_min, do_up);
                ST_EDIT_SEC: set_sec <= ms_step(set_sec, do_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt <= '0;
        end else if (!is_edit(state_nxt)) begin
            tmo_cnt <= '0;
        end else if (any_edge) begin
            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    // Blink restarts high for a full half-period on edit entry and after every step.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            blink_o   <= 1'b0;
            blink_cnt <= '0;
        end else if (!is_edit(state_nxt)) begin
            blink_o   <= 1'b0;
            blink_cnt <= '0;
        end else if (!in_edit || stepped) begin
            blink_o   <= 1'b1;
            blink_cnt <= BW'(BLINK_CYC - 1);
        end else if (blink_cnt == '0) begin
            blink_o   <= ~blink_o;
            blink_cnt <= BW'(BLINK_CYC - 1);
        end else begin
            blink_cnt <= blink_cnt - BW'(1);
        end
    end

endmodule
